// File: rtl/core_cfg_ctrl.sv
// Core configuration controller: host-writable boot/trap/debug/hart-ID registers, core reset and fetch sequencing, sleep status.
// Latency: register writes take effect 1 cycle after cfg_we; read data returns 1 cycle after cfg_re; core_rst_n_o/fetch_enable_o are registered.
// Backpressure: none; the host bus is strobe-based, and every read produces a response on the following cycle.
module core_cfg_ctrl #(
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_0080,
    parameter logic [31:0] HART_ID_RST   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic        cfg_re,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        cfg_rvalid,
    output logic        core_rst_n_o,
    output logic        fetch_enable_o,
    output logic        pulp_clock_en_o,
    output logic        scan_cg_en_o,
    output logic [31:0] boot_addr_o,
    output logic [31:0] mtvec_addr_o,
    output logic [31:0] dm_halt_addr_o,
    output logic [31:0] dm_exception_addr_o,
    output logic [31:0] hart_id_o,
    input  logic        core_sleep_i
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sleep_q, sleep_seen_q, lock_err_q;
    logic               ctrl_wr, start_cmd, stop_cmd, clr_cmd;
    logic               reg_wr, reg_wr_ok, lock_set, sleep_set;
    logic               core_rst_n_d, fetch_d;
    logic [31:0]        rd_mux;

    assign ctrl_wr   = cfg_we && (cfg_addr == 3'd5);
    assign start_cmd = ctrl_wr && cfg_wdata[0];
    assign stop_cmd  = ctrl_wr && cfg_wdata[1];
    assign clr_cmd   = ctrl_wr && cfg_wdata[3];
    assign reg_wr    = cfg_we && (cfg_addr <= 3'd4);
    assign reg_wr_ok = reg_wr && (state_q == IDLE);
    assign lock_set  = reg_wr && (state_q != IDLE);
    assign sleep_set = sleep_q && (state_q == RUN);

    assign scan_cg_en_o = 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stop_cmd) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_cmd) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(RST_CYCLES - 1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs follow the state one cycle late, so reset release lands at start+1+RST_CYCLES;
    // a stop drops them on the same edge the FSM returns to IDLE.
    assign core_rst_n_d = !stop_cmd && ((state_q == SETTLE) || (state_q == RUN));
    assign fetch_d      = !stop_cmd && (state_q == RUN);

    always_comb begin
        rd_mux = 32'd0;
        case (cfg_addr)
            3'd0: rd_mux = boot_addr_o;
            3'd1: rd_mux = mtvec_addr_o;
            3'd2: rd_mux = dm_halt_addr_o;
            3'd3: rd_mux = dm_exception_addr_o;
            3'd4: rd_mux = hart_id_o;
            3'd5: rd_mux = {29'd0, pulp_clock_en_o, 2'b00};
            3'd6: rd_mux = {27'd0, lock_err_q, sleep_seen_q, sleep_q, state_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            core_rst_n_o        <= 1'b0;
            fetch_enable_o      <= 1'b0;
            pulp_clock_en_o     <= 1'b0;
            cfg_rvalid          <= 1'b0;
            cfg_rdata           <= 32'd0;
            boot_addr_o         <= BOOT_ADDR_RST;
            mtvec_addr_o        <= 32'd0;
            dm_halt_addr_o      <= 32'd0;
            dm_exception_addr_o <= 32'd0;
            hart_id_o           <= HART_ID_RST;
            sleep_q             <= 1'b0;
            sleep_seen_q        <= 1'b0;
            lock_err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            core_rst_n_o   <= core_rst_n_d;
            fetch_enable_o <= fetch_d;
            cfg_rvalid     <= cfg_re;
            cfg_rdata      <= cfg_re ? rd_mux : 32'd0;
            sleep_q        <= core_sleep_i;
            if (ctrl_wr) begin
                pulp_clock_en_o <= cfg_wdata[2];
            end
            if (reg_wr_ok) begin
                case (cfg_addr)
                    3'd0: boot_addr_o         <= cfg_wdata;
                    3'd1: mtvec_addr_o        <= cfg_wdata;
                    3'd2: dm_halt_addr_o      <= cfg_wdata;
                    3'd3: dm_exception_addr_o <= cfg_wdata;
                    default: hart_id_o        <= cfg_wdata;
                endcase
            end
            // A set in the same cycle as clr_sticky wins.
            if (sleep_set) begin
                sleep_seen_q <= 1'b1;
            end else if (clr_cmd) begin
                sleep_seen_q <= 1'b0;
            end
            if (lock_set) begin
                lock_err_q <= 1'b1;
            end else if (clr_cmd) begin
                lock_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_cfg_ctrl.sv
// Bench for core_cfg_ctrl: directed literal checks followed by random host/sleep traffic,
// all outputs compared every cycle against an elapsed-time model of the boot sequence.
module tb_core_cfg_ctrl;

    localparam int RST_CYC = 8;
    localparam int SET_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic        cfg_re = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        core_sleep_i = 1'b0;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid;
    logic        core_rst_n_o, fetch_enable_o, pulp_clock_en_o, scan_cg_en_o;
    logic [31:0] boot_addr_o, mtvec_addr_o, dm_halt_addr_o, dm_exception_addr_o, hart_id_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_cfg_ctrl #(
        .RST_CYCLES(RST_CYC), .SETTLE_CYCLES(SET_CYC),
        .BOOT_ADDR_RST(32'h0000_0080), .HART_ID_RST(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
        .core_rst_n_o(core_rst_n_o), .fetch_enable_o(fetch_enable_o),
        .pulp_clock_en_o(pulp_clock_en_o), .scan_cg_en_o(scan_cg_en_o),
        .boot_addr_o(boot_addr_o), .mtvec_addr_o(mtvec_addr_o),
        .dm_halt_addr_o(dm_halt_addr_o), .dm_exception_addr_o(dm_exception_addr_o),
        .hart_id_o(hart_id_o), .core_sleep_i(core_sleep_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the boot sequence is a function of cycles elapsed since the accepted start.
    logic [31:0] m_reg [5];
    logic        m_pulp, m_active, m_sleep, m_seen, m_lock;
    int          m_cyc, m_start;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        chk_en = 1'b0;

    function automatic logic [1:0] m_state();
        int e;
        e = m_cyc - m_start;
        if (!m_active)                 return 2'd0;
        if (e < RST_CYC)               return 2'd1;
        if (e < RST_CYC + SET_CYC)     return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a, input logic [1:0] st);
        if (a <= 3'd4) return m_reg[a];
        if (a == 3'd5) return {29'd0, m_pulp, 2'b00};
        if (a == 3'd6) return {27'd0, m_lock, m_seen, m_sleep, st};
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        logic [1:0] st;
        if (rst) begin
            m_reg[0] = 32'h80; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0; m_reg[4] = 0;
            m_pulp = 0; m_active = 0; m_sleep = 0; m_seen = 0; m_lock = 0;
            m_cyc = 0; m_start = 0;
            exp_rvalid = 0; exp_rdata = 0;
            chk_en = 1'b1;
        end else begin
            st = m_state();
            exp_rvalid = cfg_re;
            exp_rdata  = cfg_re ? m_read(cfg_addr, st) : 32'd0;
            if (cfg_we && cfg_addr == 3'd5 && cfg_wdata[3]) begin
                m_seen = 0; m_lock = 0;
            end
            if (m_sleep && st == 2'd3) m_seen = 1;
            if (cfg_we && cfg_addr <= 3'd4) begin
                if (st == 2'd0) m_reg[cfg_addr] = cfg_wdata;
                else            m_lock = 1;
            end
            if (cfg_we && cfg_addr == 3'd5) begin
                m_pulp = cfg_wdata[2];
                if (cfg_wdata[1]) m_active = 0;
                else if (cfg_wdata[0] && st == 2'd0) begin
                    m_active = 1;
                    m_start  = m_cyc + 1;
                end
            end
            m_sleep = core_sleep_i;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rvalid", {31'd0, cfg_rvalid}, {31'd0, exp_rvalid});
            if (exp_rvalid) check("rdata", cfg_rdata, exp_rdata);
            check("core_rst_n", {31'd0, core_rst_n_o},
                  {31'd0, m_active && (m_cyc - m_start >= RST_CYC + 1)});
            check("fetch_en", {31'd0, fetch_enable_o},
                  {31'd0, m_active && (m_cyc - m_start >= RST_CYC + SET_CYC + 1)});
            check("pulp_clk_en", {31'd0, pulp_clock_en_o}, {31'd0, m_pulp});
            check("scan_cg_en", {31'd0, scan_cg_en_o}, 32'd0);
            check("boot_addr", boot_addr_o, m_reg[0]);
            check("mtvec", mtvec_addr_o, m_reg[1]);
            check("dm_halt", dm_halt_addr_o, m_reg[2]);
            check("dm_exc", dm_exception_addr_o, m_reg[3]);
            check("hart_id", hart_id_o, m_reg[4]);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_re = 1'b1; cfg_addr = a;
        @(posedge clk); #1;
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] rst_exp [8];
        int rk, fk;
        rst_exp[0] = 32'h80;
        for (int i = 1; i < 8; i++) rst_exp[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_core_rst_n", {31'd0, core_rst_n_o}, 32'd0);
        check("rst_fetch", {31'd0, fetch_enable_o}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            check($sformatf("rst_read%0d", i), d, rst_exp[i]);
        end

        // Boot sequence timing relative to the start-write edge.
        wr(3'd0, 32'h1000);
        wr(3'd4, 32'd3);
        wr(3'd5, 32'h1);
        rk = 0; fk = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (core_rst_n_o && rk == 0) rk = k;
            if (fetch_enable_o && fk == 0) fk = k;
        end
        check("rst_n_rise_cycle", rk, 9);
        check("fetch_rise_cycle", fk, 11);
        check("boot_run", boot_addr_o, 32'h1000);
        check("hart_run", hart_id_o, 32'd3);

        // Lock error in RUN and its clear.
        wr(3'd1, 32'hDEAD);
        rd(3'd1, d);  check("mtvec_locked", d, 32'd0);
        rd(3'd6, d);  check("status_lock", d, 32'h13);
        wr(3'd5, 32'h8);
        rd(3'd6, d);  check("status_clr", d, 32'h03);

        // One-cycle sleep pulse in RUN.
        @(negedge clk) core_sleep_i = 1'b1;
        @(posedge clk); #1 core_sleep_i = 1'b0;
        rd(3'd6, d);  check("status_sleep", d, 32'h07);
        rd(3'd6, d);  check("status_seen", d, 32'h0B);

        // Stop, restart, then start+stop while in HOLD.
        wr(3'd5, 32'h2);
        wr(3'd5, 32'h1);
        wr(3'd5, 32'h3);
        check("hold_stop_rst_n", {31'd0, core_rst_n_o}, 32'd0);
        rd(3'd6, d);  check("hold_stop_status", d, 32'h08);
        repeat (12) @(posedge clk);
        #1 check("idle_rst_n_low", {31'd0, core_rst_n_o}, 32'd0);

        // Reset during SETTLE.
        wr(3'd5, 32'h9);
        repeat (9) @(posedge clk);
        #1;
        check("settle_rst_n", {31'd0, core_rst_n_o}, 32'd1);
        check("settle_fetch", {31'd0, fetch_enable_o}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_core_rst_n", {31'd0, core_rst_n_o}, 32'd0);
        check("mid_rst_fetch", {31'd0, fetch_enable_o}, 32'd0);
        check("mid_rst_boot", boot_addr_o, 32'h80);
        rst = 1'b0;
        rd(3'd6, d);  check("mid_rst_status", d, 32'd0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 599) == 0);
            cfg_we       = ($urandom_range(0, 4) == 0);
            cfg_re       = ($urandom_range(0, 2) == 0);
            cfg_addr     = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
            cfg_wdata    = $urandom;
            if (cfg_addr == 3'd5) cfg_wdata[1] = ($urandom_range(0, 7) == 0);
            core_sleep_i = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0; core_sleep_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
